// File: rtl/johnson_sequence_checker.sv
// Receive-side checker for a 3-bit Johnson counter: decodes phase, counts steps, flags faults, drives one 7-seg digit.
// Optional build macro JOHNSON_REVERSE_EN accepts single reverse steps as legal (step_count decrements).
module johnson_sequence_checker #(
  parameter int COUNT_W  = 8,
  parameter int LOCK_CNT = 6
) (
  input  logic               in_clk,
  input  logic               rst,
  input  logic [2:0]         jc_in,
  input  logic               sample_en,
  input  logic               clear_err,
  output logic [2:0]         phase,
  output logic               valid,
  output logic [COUNT_W-1:0] step_count,
  output logic               locked,
  output logic               err_illegal,
  output logic               err_skip,
  output logic [7:0]         Seven_Seg,
  output logic [3:0]         digit
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAULT} state_t;

  localparam logic [3:0] LOCK_GOOD = 4'(LOCK_CNT);

  state_t     state;
  logic [3:0] good;

  logic [2:0] dec_phase;
  logic       dec_legal;
  logic [2:0] fwd_phase;
  logic       is_same;
  logic       is_fwd;
  logic       is_rev;
  logic [3:0] good_inc;

  always_comb begin
    dec_phase = 3'd0;
    dec_legal = 1'b1;
    case (jc_in)
      3'b000:  dec_phase = 3'd0;
      3'b100:  dec_phase = 3'd1;
      3'b110:  dec_phase = 3'd2;
      3'b111:  dec_phase = 3'd3;
      3'b011:  dec_phase = 3'd4;
      3'b001:  dec_phase = 3'd5;
      default: dec_legal = 1'b0;
    endcase
  end

  // Neighbour phases around the current one, with 5<->0 wrap.
  always_comb begin
    fwd_phase = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    is_same   = (dec_phase == phase);
    is_fwd    = (dec_phase == fwd_phase);
`ifdef JOHNSON_REVERSE_EN
    is_rev    = (dec_phase == ((phase == 3'd0) ? 3'd5 : phase - 3'd1));
`else
    is_rev    = 1'b0;
`endif
    good_inc  = (good >= LOCK_GOOD) ? LOCK_GOOD : good + 4'd1;
  end

  // Clear is written first so that a simultaneous error event wins.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      good        <= 4'd0;
      phase       <= 3'd0;
      valid       <= 1'b0;
      step_count  <= '0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
    end else begin
      if (clear_err) begin
        err_illegal <= 1'b0;
        err_skip    <= 1'b0;
      end
      if (sample_en) begin
        case (state)
          IDLE, FAULT: begin
            if (dec_legal) begin
              state <= TRACK;
              phase <= dec_phase;
              valid <= 1'b1;
              good  <= 4'd0;
            end else begin
              state       <= FAULT;
              valid       <= 1'b0;
              err_illegal <= 1'b1;
            end
            locked <= 1'b0;
          end
          TRACK, LOCKED: begin
            if (!dec_legal) begin
              state       <= FAULT;
              err_illegal <= 1'b1;
              valid       <= 1'b0;
              good        <= 4'd0;
              locked      <= 1'b0;
            end else if (is_same) begin
              good <= good;
            end else if (is_fwd || is_rev) begin
              phase      <= dec_phase;
              step_count <= is_fwd ? step_count + COUNT_W'(1) : step_count - COUNT_W'(1);
              good       <= good_inc;
              if (good_inc == LOCK_GOOD) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              state    <= TRACK;
              err_skip <= 1'b1;
              phase    <= dec_phase;
              good     <= 4'd0;
              locked   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            valid  <= 1'b0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Glyph decode straight from registered state; dp mirrors locked.
  always_comb begin
    Seven_Seg = 8'b0100_0000;
    case (state)
      IDLE:    Seven_Seg = 8'b0100_0000;
      FAULT:   Seven_Seg = 8'b0111_1001;
      default: begin
        case (phase)
          3'd0:    Seven_Seg = 8'h3F;
          3'd1:    Seven_Seg = 8'h06;
          3'd2:    Seven_Seg = 8'h5B;
          3'd3:    Seven_Seg = 8'h4F;
          3'd4:    Seven_Seg = 8'h66;
          3'd5:    Seven_Seg = 8'h6D;
          default: Seven_Seg = 8'h00;
        endcase
        Seven_Seg[7] = locked;
      end
    endcase
  end

  assign digit = 4'b0001;

endmodule

// File: tb/tb_johnson_sequence_checker.sv
// Table-driven bench for johnson_sequence_checker plus hand sequences for counter wrap and async reset.
module tb_johnson_sequence_checker;

  logic       in_clk = 1'b0;
  logic       rst;
  logic [2:0] jc_in;
  logic       sample_en;
  logic       clear_err;
  logic [2:0] phase;
  logic       valid;
  logic [7:0] step_count;
  logic       locked;
  logic       err_illegal;
  logic       err_skip;
  logic [7:0] Seven_Seg;
  logic [3:0] digit;

  logic [2:0] jc_w;
  logic       se_w;
  logic [2:0] phase_w;
  logic       valid_w;
  logic [2:0] step_w;
  logic       locked_w;
  logic       eill_w;
  logic       eskip_w;
  logic [7:0] seg_w;
  logic [3:0] digit_w;

  always #5 in_clk = ~in_clk;

  johnson_sequence_checker #(.COUNT_W(8), .LOCK_CNT(6)) u_dut (
    .in_clk(in_clk), .rst(rst), .jc_in(jc_in), .sample_en(sample_en), .clear_err(clear_err),
    .phase(phase), .valid(valid), .step_count(step_count), .locked(locked),
    .err_illegal(err_illegal), .err_skip(err_skip), .Seven_Seg(Seven_Seg), .digit(digit)
  );

  johnson_sequence_checker #(.COUNT_W(3), .LOCK_CNT(6)) u_wrap (
    .in_clk(in_clk), .rst(rst), .jc_in(jc_w), .sample_en(se_w), .clear_err(1'b0),
    .phase(phase_w), .valid(valid_w), .step_count(step_w), .locked(locked_w),
    .err_illegal(eill_w), .err_skip(eskip_w), .Seven_Seg(seg_w), .digit(digit_w)
  );

  typedef struct {
    logic       se;
    logic       clr;
    logic [2:0] jc;
    logic [2:0] ph;
    logic       vl;
    logic [7:0] st;
    logic       lk;
    logic       ei;
    logic       es;
    logic [7:0] seg;
  } vec_t;

  localparam int NV = 37;
  vec_t vt[NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic se, input logic clr, input logic [2:0] jc,
                              input logic [2:0] ph, input logic vl, input logic [7:0] st,
                              input logic lk, input logic ei, input logic es, input logic [7:0] seg);
    vec_t v;
    v.se = se; v.clr = clr; v.jc = jc; v.ph = ph; v.vl = vl;
    v.st = st; v.lk = lk; v.ei = ei; v.es = es; v.seg = seg;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] ph, input logic vl, input logic [7:0] st,
                       input logic lk, input logic ei, input logic es, input logic [7:0] seg);
    n_vec++;
    if (phase !== ph || valid !== vl || step_count !== st || locked !== lk ||
        err_illegal !== ei || err_skip !== es || Seven_Seg !== seg || digit !== 4'b0001) begin
      n_bad++;
      $display("FAIL %s: got ph=%0d v=%0b st=%0d lk=%0b ei=%0b es=%0b seg=%h dig=%b; want ph=%0d v=%0b st=%0d lk=%0b ei=%0b es=%0b seg=%h dig=0001",
               name, phase, valid, step_count, locked, err_illegal, err_skip, Seven_Seg, digit,
               ph, vl, st, lk, ei, es, seg);
    end
  endtask

  task automatic apply(input logic se, input logic clr, input logic [2:0] jc);
    @(negedge in_clk);
    sample_en = se;
    clear_err = clr;
    jc_in     = jc;
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    logic [2:0] codes [6];
    codes[0] = 3'b000; codes[1] = 3'b100; codes[2] = 3'b110;
    codes[3] = 3'b111; codes[4] = 3'b011; codes[5] = 3'b001;

    vt[0]  = mk(1,0,3'b000, 3'd0,1,8'd0, 0,0,0,8'h3F);
    vt[1]  = mk(1,0,3'b100, 3'd1,1,8'd1, 0,0,0,8'h06);
    vt[2]  = mk(1,0,3'b110, 3'd2,1,8'd2, 0,0,0,8'h5B);
    vt[3]  = mk(1,0,3'b111, 3'd3,1,8'd3, 0,0,0,8'h4F);
    vt[4]  = mk(1,0,3'b011, 3'd4,1,8'd4, 0,0,0,8'h66);
    vt[5]  = mk(1,0,3'b001, 3'd5,1,8'd5, 0,0,0,8'h6D);
    vt[6]  = mk(1,0,3'b000, 3'd0,1,8'd6, 1,0,0,8'hBF);
    vt[7]  = mk(0,0,3'b101, 3'd0,1,8'd6, 1,0,0,8'hBF);
    vt[8]  = mk(1,0,3'b000, 3'd0,1,8'd6, 1,0,0,8'hBF);
    vt[9]  = mk(1,0,3'b100, 3'd1,1,8'd7, 1,0,0,8'h86);
    vt[10] = mk(1,0,3'b110, 3'd2,1,8'd8, 1,0,0,8'hDB);
    vt[11] = mk(1,0,3'b111, 3'd3,1,8'd9, 1,0,0,8'hCF);
    vt[12] = mk(1,0,3'b101, 3'd3,0,8'd9, 0,1,0,8'h79);
    vt[13] = mk(1,0,3'b010, 3'd3,0,8'd9, 0,1,0,8'h79);
    vt[14] = mk(1,0,3'b011, 3'd4,1,8'd9, 0,1,0,8'h66);
    vt[15] = mk(0,1,3'b000, 3'd4,1,8'd9, 0,0,0,8'h66);
    vt[16] = mk(1,0,3'b001, 3'd5,1,8'd10,0,0,0,8'h6D);
    vt[17] = mk(1,0,3'b000, 3'd0,1,8'd11,0,0,0,8'h3F);
    vt[18] = mk(1,0,3'b100, 3'd1,1,8'd12,0,0,0,8'h06);
    vt[19] = mk(1,0,3'b110, 3'd2,1,8'd13,0,0,0,8'h5B);
    vt[20] = mk(1,0,3'b111, 3'd3,1,8'd14,0,0,0,8'h4F);
    vt[21] = mk(1,0,3'b011, 3'd4,1,8'd15,1,0,0,8'hE6);
    vt[22] = mk(1,0,3'b001, 3'd5,1,8'd16,1,0,0,8'hED);
    vt[23] = mk(1,0,3'b000, 3'd0,1,8'd17,1,0,0,8'hBF);
    vt[24] = mk(1,0,3'b100, 3'd1,1,8'd18,1,0,0,8'h86);
    vt[25] = mk(1,0,3'b111, 3'd3,1,8'd18,0,0,1,8'h4F);
    vt[26] = mk(1,0,3'b011, 3'd4,1,8'd19,0,0,1,8'h66);
    vt[27] = mk(1,0,3'b001, 3'd5,1,8'd20,0,0,1,8'h6D);
    vt[28] = mk(1,0,3'b000, 3'd0,1,8'd21,0,0,1,8'h3F);
    vt[29] = mk(1,0,3'b100, 3'd1,1,8'd22,0,0,1,8'h06);
    vt[30] = mk(1,0,3'b110, 3'd2,1,8'd23,0,0,1,8'h5B);
    vt[31] = mk(1,0,3'b111, 3'd3,1,8'd24,1,0,1,8'hCF);
    vt[32] = mk(0,1,3'b000, 3'd3,1,8'd24,1,0,0,8'hCF);
    vt[33] = mk(1,1,3'b010, 3'd3,0,8'd24,0,1,0,8'h79);
    vt[34] = mk(0,1,3'b000, 3'd3,0,8'd24,0,0,0,8'h79);
    vt[35] = mk(1,0,3'b110, 3'd2,1,8'd24,0,0,0,8'h5B);
`ifdef JOHNSON_REVERSE_EN
    vt[36] = mk(1,0,3'b100, 3'd1,1,8'd23,0,0,0,8'h06);
`else
    vt[36] = mk(1,0,3'b100, 3'd1,1,8'd24,0,0,1,8'h06);
`endif

    rst = 1'b0; jc_in = 3'b000; sample_en = 1'b0; clear_err = 1'b0;
    jc_w = 3'b000; se_w = 1'b0;
    #12;
    check("reset", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h40);
    @(negedge in_clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vt[i].se, vt[i].clr, vt[i].jc);
      check($sformatf("vec%0d", i), vt[i].ph, vt[i].vl, vt[i].st, vt[i].lk, vt[i].ei, vt[i].es, vt[i].seg);
    end
    @(negedge in_clk);
    sample_en = 1'b0;
    clear_err = 1'b0;

    // Narrow counter: ten samples from phase 0 are nine forward steps, 9 mod 8 = 1.
    for (int i = 0; i < 10; i++) begin
      @(negedge in_clk);
      se_w = 1'b1;
      jc_w = codes[i % 6];
    end
    @(negedge in_clk);
    se_w = 1'b0;
    n_vec++;
    if (step_w !== 3'd1 || phase_w !== 3'd3 || locked_w !== 1'b1 || valid_w !== 1'b1) begin
      n_bad++;
      $display("FAIL count_wrap: got st=%0d ph=%0d lk=%0b v=%0b; want st=1 ph=3 lk=1 v=1",
               step_w, phase_w, locked_w, valid_w);
    end

    // Reset asserted mid-cycle must take effect before the next clock edge.
    @(negedge in_clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset", 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h40);
    n_vec++;
    if (step_w !== 3'd0 || locked_w !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_wrap: got st=%0d lk=%0b; want st=0 lk=0", step_w, locked_w);
    end
    @(negedge in_clk);
    rst = 1'b1;
    apply(1'b1, 1'b0, 3'b101);
    check("idle_illegal", 3'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'h79);
    apply(1'b1, 1'b0, 3'b001);
    check("fault_recover", 3'd5, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 8'h6D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
